// File: rtl/enc_pwm_mixer_pkg.sv
// Shared definitions for the encoder/PWM mixer: quadrature transition codes,
// level arithmetic modes and the flattened level-bus index helper.
`timescale 1ns/1ps
package enc_pwm_mixer_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_INC  = 2'd1,
      DIR_DEC  = 2'd2
   } dir_e;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // {prev_ab, cur_ab}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00
   localparam logic [3:0] INC_00_10 = 4'b00_10;
   localparam logic [3:0] INC_10_11 = 4'b10_11;
   localparam logic [3:0] INC_11_01 = 4'b11_01;
   localparam logic [3:0] INC_01_00 = 4'b01_00;
   localparam logic [3:0] DEC_10_00 = 4'b10_00;
   localparam logic [3:0] DEC_11_10 = 4'b11_10;
   localparam logic [3:0] DEC_01_11 = 4'b01_11;
   localparam logic [3:0] DEC_00_01 = 4'b00_01;

   function automatic dir_e quad_dir(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      dir_e d;
      case ({prev_ab, cur_ab})
         INC_00_10, INC_10_11, INC_11_01, INC_01_00: d = DIR_INC;
         DEC_10_00, DEC_11_10, DEC_01_11, DEC_00_01: d = DIR_DEC;
         default:                                    d = DIR_NONE;
      endcase
      return d;
   endfunction

   function automatic int lvl_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/enc_pwm_mixer_channel.sv
// One mixer channel: debounces both phases, decodes x4 quadrature into a level
// with preset/clamp/wrap, latches it per PWM period and drives the compare output.
`timescale 1ns/1ps
module enc_pwm_mixer_channel
   import enc_pwm_mixer_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DB_TICKS = 8,
   parameter int STEP     = 1,
   parameter int SATURATE = 1,
   parameter int INVERT   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             wrap,
   input  logic             a_sync,
   input  logic             b_sync,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] pwm_cnt,
   output logic [WIDTH-1:0] level,
   output logic             pwm
);

   localparam int             DBW     = $clog2(DB_TICKS) + 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
   localparam logic [WIDTH:0] LVL_MAX = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
   localparam bit             CLAMP   = (SATURATE != MODE_WRAP);

   logic [1:0]       phase_sync;
   logic [1:0]       db;
   logic [1:0]       prev_q, prev_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pwm_q, pwm_d;
   logic [WIDTH:0]   level_up, level_dn;
   dir_e             dir;

   assign phase_sync = {a_sync, b_sync};

   // Index 1 is phase A, index 0 is phase B, matching the {a,b} pair order.
   for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic           bit_q, bit_d;
      logic [DBW-1:0] cnt_q, cnt_d;

      always_comb begin
         bit_d = bit_q;
         cnt_d = cnt_q;
         if (tick) begin
            if (phase_sync[gi] == bit_q) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               bit_d = phase_sync[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            bit_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            bit_q <= bit_d;
            cnt_q <= cnt_d;
         end
      end

      assign db[gi] = bit_q;
   end

   always_comb begin
      dir      = quad_dir(prev_q, db);
      prev_d   = tick ? db : prev_q;
      level_up = {1'b0, level_q} + STEP_X;
      level_dn = {1'b0, level_q} - STEP_X;
      level_d  = level_q;
      if (load_en) begin
         level_d = load_value;
      end else if (tick && dir == DIR_INC) begin
         level_d = (CLAMP && level_up > LVL_MAX) ? LVL_MAX[WIDTH-1:0] : level_up[WIDTH-1:0];
      end else if (tick && dir == DIR_DEC) begin
         // a set borrow bit means the step went below zero
         level_d = (CLAMP && level_dn[WIDTH]) ? '0 : level_dn[WIDTH-1:0];
      end
      shadow_d = wrap ? level_q : shadow_q;
      pwm_d    = (pwm_cnt < shadow_q) ^ (INVERT != 0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q   <= 2'b00;
         level_q  <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         prev_q   <= prev_d;
         level_q  <= level_d;
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
      end
   end

   assign level = level_q;
   assign pwm   = pwm_q;

endmodule

// File: rtl/enc_pwm_mixer.sv
// N-channel quadrature-encoder to PWM mixer: input synchronisers, shared tick
// prescaler and PWM period counter, one enc_pwm_mixer_channel per encoder.
`timescale 1ns/1ps
module enc_pwm_mixer
   import enc_pwm_mixer_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int WIDTH    = 8,
   parameter int CLK_DIV  = 256,
   parameter int DB_TICKS = 8,
   parameter int STEP     = 1,
   parameter int SATURATE = 1,
   parameter int INVERT   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       enc_a,
   input  logic [NUM_CH-1:0]       enc_b,
   input  logic                    load_valid,
   input  logic [3:0]              load_ch,
   input  logic [WIDTH-1:0]        load_value,
   output logic [NUM_CH*WIDTH-1:0] level_out,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic                    period_start
);

   localparam int               PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [WIDTH-1:0] CNT_LAST   = WIDTH'((1 << WIDTH) - 2);

   logic [NUM_CH-1:0] a_meta_q, a_meta_d, a_sync_q, a_sync_d;
   logic [NUM_CH-1:0] b_meta_q, b_meta_d, b_sync_q, b_sync_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic              period_start_q, period_start_d;
   logic              tick;
   logic              wrap;

   always_comb begin
      a_meta_d       = enc_a;
      a_sync_d       = a_meta_q;
      b_meta_d       = enc_b;
      b_sync_d       = b_meta_q;
      tick           = (presc_q == PRESC_LAST);
      presc_d        = tick ? '0 : presc_q + 1'b1;
      // counter spans 0..2^WIDTH-2 so a full-scale level is on all period
      wrap           = tick && (pwm_cnt_q == CNT_LAST);
      pwm_cnt_d      = pwm_cnt_q;
      if (tick) begin
         pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;
      end
      period_start_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_meta_q       <= '0;
         a_sync_q       <= '0;
         b_meta_q       <= '0;
         b_sync_q       <= '0;
         presc_q        <= '0;
         pwm_cnt_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         a_meta_q       <= a_meta_d;
         a_sync_q       <= a_sync_d;
         b_meta_q       <= b_meta_d;
         b_sync_q       <= b_sync_d;
         presc_q        <= presc_d;
         pwm_cnt_q      <= pwm_cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign period_start = period_start_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int LSB = lvl_lsb(gi, WIDTH);
      logic             load_hit;
      logic [WIDTH-1:0] ch_level;

      // out-of-range load_ch values match no channel and are dropped
      assign load_hit = load_valid && (load_ch == 4'(gi));

      enc_pwm_mixer_channel #(
         .WIDTH    (WIDTH),
         .DB_TICKS (DB_TICKS),
         .STEP     (STEP),
         .SATURATE (SATURATE),
         .INVERT   (INVERT)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .wrap       (wrap),
         .a_sync     (a_sync_q[gi]),
         .b_sync     (b_sync_q[gi]),
         .load_en    (load_hit),
         .load_value (load_value),
         .pwm_cnt    (pwm_cnt_q),
         .level      (ch_level),
         .pwm        (pwm_out[gi])
      );

      assign level_out[LSB +: WIDTH] = ch_level;
   end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
// Bench for enc_pwm_mixer: a saturating/non-inverted and a wrapping/inverted
// instance share stimulus and are checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_enc_pwm_mixer;

   localparam int NCH  = 3;
   localparam int W    = 8;
   localparam int CDIV = 4;
   localparam int DBT  = 4;
   localparam int STP  = 1;
   localparam int PER  = (1 << W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NCH-1:0]   enc_a = '0;
   logic [NCH-1:0]   enc_b = '0;
   logic             load_valid = 1'b0;
   logic [3:0]       load_ch = '0;
   logic [W-1:0]     load_value = '0;
   logic [NCH*W-1:0] lvl0, lvl1;
   logic [NCH-1:0]   pwm0, pwm1;
   logic             ps0, ps1;

   always #5 clk = ~clk;

   enc_pwm_mixer #(.NUM_CH(NCH), .WIDTH(W), .CLK_DIV(CDIV), .DB_TICKS(DBT), .STEP(STP),
                   .SATURATE(1), .INVERT(0)) dut0 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load_valid(load_valid),
      .load_ch(load_ch), .load_value(load_value), .level_out(lvl0), .pwm_out(pwm0),
      .period_start(ps0));

   enc_pwm_mixer #(.NUM_CH(NCH), .WIDTH(W), .CLK_DIV(CDIV), .DB_TICKS(DBT), .STEP(STP),
                   .SATURATE(0), .INVERT(1)) dut1 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .load_valid(load_valid),
      .load_ch(load_ch), .load_value(load_value), .level_out(lvl1), .pwm_out(pwm1),
      .period_start(ps1));

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int idx, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model (instance 0: clamp, 1: wrap+invert) ----------
   bit             mvalid = 0;
   int             m_e, m_nt;
   bit [NCH-1:0]   h1a, h2a, h1b, h2b;
   bit [1:0]       m_db   [NCH];
   bit [1:0]       m_prev [NCH];
   int             m_run  [NCH][2];
   int             m_lvl    [2][NCH];
   int             m_shadow [2][NCH];
   bit [NCH-1:0]   x_pwm [2];
   bit             x_ps;

   function automatic int gpos(input bit [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_edge();
      bit       tk, ld;
      bit [1:0] syn;
      int       d, nv;
      if (reset) begin
         mvalid = 1; m_e = 0; m_nt = 0; x_ps = 0;
         h1a = '0; h2a = '0; h1b = '0; h2b = '0;
         for (int k = 0; k < 2; k++) begin
            x_pwm[k] = '0;
            for (int c = 0; c < NCH; c++) begin m_lvl[k][c] = 0; m_shadow[k][c] = 0; end
         end
         for (int c = 0; c < NCH; c++) begin
            m_db[c] = 2'b00; m_prev[c] = 2'b00; m_run[c][0] = 0; m_run[c][1] = 0;
         end
         return;
      end
      tk = (m_e % CDIV) == CDIV - 1;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++)
            x_pwm[k][c] = ((m_nt % PER) < m_shadow[k][c]) ^ (k == 1);
      x_ps = tk && ((m_nt % PER) == PER - 1);
      if (x_ps)
         for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) m_shadow[k][c] = m_lvl[k][c];
      for (int c = 0; c < NCH; c++) begin
         ld = load_valid && (int'(load_ch) == c);
         if (tk) begin
            syn = {h2a[c], h2b[c]};
            d = (gpos(m_db[c]) - gpos(m_prev[c]) + 4) % 4;
            m_prev[c] = m_db[c];
            for (int p = 0; p < 2; p++) begin
               if (syn[p] != m_db[c][p]) begin
                  m_run[c][p]++;
                  if (m_run[c][p] == DBT) begin m_db[c][p] = syn[p]; m_run[c][p] = 0; end
               end else m_run[c][p] = 0;
            end
            if (!ld && (d == 1 || d == 3))
               for (int k = 0; k < 2; k++) begin
                  nv = m_lvl[k][c] + ((d == 1) ? STP : -STP);
                  if (k == 0) nv = (nv < 0) ? 0 : (nv > PER) ? PER : nv;
                  else        nv = nv & PER;
                  m_lvl[k][c] = nv;
               end
         end
         if (ld) for (int k = 0; k < 2; k++) m_lvl[k][c] = int'(load_value);
      end
      h2a = h1a; h1a = enc_a; h2b = h1b; h1b = enc_b;
      if (tk) m_nt++;
      m_e++;
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   // ---------------- per-cycle compare -----------------------------------------------
   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         for (int c = 0; c < NCH; c++) begin
            check("level0", c, int'(lvl0[c*W +: W]), m_lvl[0][c]);
            check("level1", c, int'(lvl1[c*W +: W]), m_lvl[1][c]);
         end
         check("pwm0", 0, int'(pwm0), int'(x_pwm[0]));
         check("pwm1", 1, int'(pwm1), int'(x_pwm[1]));
         check("period_start0", 0, int'(ps0), int'(x_ps));
         check("period_start1", 1, int'(ps1), int'(x_ps));
      end
   end

   // ---------------- stimulus helpers ------------------------------------------------
   int pos [NCH] = '{default: 0};

   task automatic apply_pos(input int c);
      case (pos[c])
         0:       begin enc_a[c] = 1'b0; enc_b[c] = 1'b0; end
         1:       begin enc_a[c] = 1'b1; enc_b[c] = 1'b0; end
         2:       begin enc_a[c] = 1'b1; enc_b[c] = 1'b1; end
         default: begin enc_a[c] = 1'b0; enc_b[c] = 1'b1; end
      endcase
   endtask

   task automatic hold(input int ticks);
      repeat (ticks * CDIV) @(negedge clk);
   endtask

   task automatic move(input int c, input int dir, input int ticks);
      pos[c] = (pos[c] + dir + 4) % 4;
      apply_pos(c);
      $display("[%0t] move ch%0d dir %0d -> pos %0d, hold %0d ticks", $time, c, dir, pos[c], ticks);
      hold(ticks);
   endtask

   task automatic do_load(input int c, input int v);
      load_valid = 1'b1; load_ch = 4'(c); load_value = W'(v);
      $display("[%0t] load ch%0d <= %0d", $time, c, v);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic wait_ps(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (ps0 !== 1'b1 && n < 3000);
      if (n >= 3000) check("period_start_timeout", 0, 0, 1);
   endtask

   task automatic count_high(input int c, output int hi0, output int hi1);
      hi0 = 0; hi1 = 0;
      repeat (PER * CDIV) begin
         @(negedge clk);
         hi0 += int'(pwm0[c]);
         hi1 += int'(pwm1[c]);
      end
   endtask

   function automatic int lv(input int k, input int c);
      return (k == 0) ? int'(lvl0[c*W +: W]) : int'(lvl1[c*W +: W]);
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed then random sequence ------------------------------------
   initial begin
      int n, h0, h1, r, c;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n = 1;
      check("reset_level0", 0, int'(lvl0), 0);
      check("reset_pwm0", 0, int'(pwm0), 0);
      while (ps0 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      check("first_period_start_clk", 0, n, 1020);
      check("model_first_ps", 0, int'(x_ps), 1);
      wait_ps(n);
      check("period_interval_clk", 0, n, 1020);

      // one clockwise detent and back on ch0
      repeat (4) move(0, 1, 8);
      check("cw_detent_ch0", 0, lv(0, 0), 4);
      check("model_cw_detent", 0, m_lvl[0][0], 4);
      check("cw_detent_ch1", 1, lv(0, 1), 0);
      check("cw_detent_ch2", 2, lv(0, 2), 0);
      repeat (4) move(0, -1, 8);
      check("ccw_detent_ch0", 0, lv(0, 0), 0);

      // glitch on ch1 phase A
      enc_a[1] = 1'b1; hold(3); enc_a[1] = 1'b0; hold(8);
      check("glitch_ch1", 1, lv(0, 1), 0);
      pos[1] = 1; apply_pos(1); hold(4); hold(4);
      check("debounced_ch1", 1, lv(0, 1), 1);
      check("model_debounced_ch1", 1, m_lvl[0][1], 1);

      // saturation vs wrap
      move(0, -1, 8);
      check("sat_floor", 0, lv(0, 0), 0);
      check("wrap_under", 0, lv(1, 0), 255);
      check("model_wrap_under", 0, m_lvl[1][0], 255);
      move(0, 1, 8);
      check("wrap_over", 0, lv(1, 0), 0);
      do_load(0, 254);
      check("load_254", 0, lv(0, 0), 254);
      repeat (4) move(0, 1, 8);
      check("sat_ceiling", 0, lv(0, 0), 255);
      check("wrap_254_plus4", 0, lv(1, 0), 2);
      wait_ps(n);
      count_high(0, h0, h1);
      check("full_on_high_clk", 0, h0, 1020);
      check("inv_level2_high_clk", 0, h1, 1012);

      // mid-period preset on ch2
      hold(50);
      do_load(2, 128);
      check("load_latency_ch2", 2, lv(0, 2), 128);
      h0 = 0; n = 0;
      while (ps0 !== 1'b1 && n < 3000) begin @(negedge clk); n++; h0 += int'(pwm0[2]); end
      check("ch2_unchanged_before_ps", 2, h0, 0);
      count_high(2, h0, h1);
      check("ch2_duty128_high_clk", 2, h0, 512);
      check("ch2_inv_duty128_high_clk", 2, h1, 508);

      // preset outranks a concurrent step
      pos[0] = (pos[0] + 1) % 4; apply_pos(0);
      load_valid = 1'b1; load_ch = 4'd0; load_value = 8'd50;
      $display("[%0t] load ch0 <= 50 held across a CW edge", $time);
      hold(10);
      load_valid = 1'b0;
      @(negedge clk);
      check("load_beats_step0", 0, lv(0, 0), 50);
      check("load_beats_step1", 0, lv(1, 0), 50);
      move(0, -1, 8);
      check("after_load_ccw", 0, lv(0, 0), 49);
      do_load(5, 77);
      check("bad_ch_ch0", 0, lv(0, 0), 49);
      check("bad_ch_ch2", 2, lv(0, 2), 128);

      // reset mid-period, then inverted idle
      do_load(0, 100);
      hold(30);
      for (int i = 0; i < NCH; i++) begin pos[i] = 0; apply_pos(i); end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_level0", 0, int'(lvl0), 0);
      check("midrst_level1", 1, int'(lvl1), 0);
      check("midrst_pwm1", 1, int'(pwm1), 0);
      check("midrst_ps", 0, int'(ps0), 0);
      reset = 1'b0;
      @(negedge clk);
      check("inv_idle_pwm1", 1, int'(pwm1), 7);
      check("noninv_idle_pwm0", 0, int'(pwm0), 0);

      // randomized phase walks, glitches and presets
      for (int it = 0; it < 300; it++) begin
         c = $urandom_range(0, NCH - 1);
         r = $urandom_range(0, 9);
         if (r < 6) begin
            move(c, (r < 3) ? 1 : -1, $urandom_range(1, 10));
         end else if (r < 8) begin
            if ($urandom_range(0, 1) == 1) enc_a[c] = ~enc_a[c];
            else                           enc_b[c] = ~enc_b[c];
            $display("[%0t] glitch ch%0d", $time, c);
            hold($urandom_range(1, 3));
            apply_pos(c);
            hold($urandom_range(1, 2));
         end else begin
            do_load($urandom_range(0, 7), $urandom_range(0, 255));
            hold($urandom_range(0, 3));
         end
      end
      hold(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
